// File: rtl/media_movel_hcsr04_pkg.sv
// Shared types and helpers for the moving-average block: FSM encoding,
// BCD widths and the double-dabble step used by the serial converter.
package media_movel_hcsr04_pkg;

    localparam int DIGITO_W = 4;
    localparam int BCD_W    = 12;
    localparam int BIN_W    = 10;
    localparam int PASSOS   = 10;
    localparam int DD_W     = BCD_W + BIN_W;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ACUMULA  = 3'd1,
        CARREGA  = 3'd2,
        CONVERTE = 3'd3,
        PRONTO   = 3'd4
    } estado_t;

    function automatic logic bcd_invalido(input logic [BCD_W-1:0] v);
        return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    function automatic logic [BIN_W-1:0] bcd_para_bin(input logic [BCD_W-1:0] v);
        return (10'(v[11:8]) * 10'd100) + (10'(v[7:4]) * 10'd10) + 10'(v[3:0]);
    endfunction

    // One double-dabble step over {bcd, bin}: correct nibbles >= 5, then shift.
    function automatic logic [DD_W-1:0] passo_dd(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        for (int n = 0; n < 3; n++) begin
            if (t[BIN_W+DIGITO_W*n +: DIGITO_W] >= 4'd5)
                t[BIN_W+DIGITO_W*n +: DIGITO_W] = t[BIN_W+DIGITO_W*n +: DIGITO_W] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/media_movel_hcsr04_binario_bcd_serial.sv
// Serial binary-to-BCD converter: one double-dabble step per cycle, PASSOS steps.
// bcd/pronto present the result of the step being taken at the current edge.
module binario_bcd_serial
    import media_movel_hcsr04_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inicia,
    input  logic [BIN_W-1:0]  bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              pronto
);

    logic [DD_W-1:0] desloc;
    logic [DD_W-1:0] proximo;
    logic [3:0]      cnt;
    logic            ativo;

    assign proximo = passo_dd(desloc);
    // Flags the final step so the consumer can capture bcd on that same edge.
    assign pronto  = ativo && (cnt == 4'(PASSOS - 1));
    assign bcd     = proximo[DD_W-1:BIN_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            desloc <= '0;
            cnt    <= '0;
            ativo  <= 1'b0;
        end else if (inicia) begin
            desloc <= {{BCD_W{1'b0}}, bin};
            cnt    <= '0;
            ativo  <= 1'b1;
        end else if (ativo) begin
            desloc <= proximo;
            cnt    <= cnt + 4'd1;
            if (pronto)
                ativo <= 1'b0;
        end
    end

endmodule

// File: rtl/media_movel_hcsr04.sv
// Moving average of validated BCD distance samples over a 2**LOG2_AMOSTRAS window,
// reported in binary and BCD with a one-cycle pronto pulse.
module media_movel_hcsr04
    import media_movel_hcsr04_pkg::*;
#(
    parameter int LOG2_AMOSTRAS = 2,
    parameter int LARG_BIN      = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                registra,
    input  logic [BCD_W-1:0]    distancia,
    output logic [BCD_W-1:0]    media,
    output logic [BIN_W-1:0]    media_bin,
    output logic                pronto,
    output logic                ocupado,
    output logic                erro
);

    localparam int PROF   = 1 << LOG2_AMOSTRAS;
    localparam int SOMA_W = LARG_BIN + LOG2_AMOSTRAS;

    estado_t                    estado;
    logic [LARG_BIN-1:0]        amostra;
    logic [LARG_BIN-1:0]        buffer [PROF];
    logic [LOG2_AMOSTRAS-1:0]   ptr;
    logic [SOMA_W-1:0]          soma;
    logic                       primeira;
    logic [BIN_W-1:0]           media_calc;
    logic [BIN_W-1:0]           conv_bin;
    logic [BCD_W-1:0]           conv_bcd;
    logic                       conv_pronto;

    assign conv_bin = BIN_W'(soma >> LOG2_AMOSTRAS);

    binario_bcd_serial u_conv (
        .clock  (clock),
        .reset  (reset),
        .inicia (estado == CARREGA),
        .bin    (conv_bin),
        .bcd    (conv_bcd),
        .pronto (conv_pronto)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= OCIOSO;
            amostra    <= '0;
            ptr        <= '0;
            soma       <= '0;
            primeira   <= 1'b1;
            media_calc <= '0;
            media      <= '0;
            media_bin  <= '0;
            pronto     <= 1'b0;
            ocupado    <= 1'b0;
            erro       <= 1'b0;
            for (int i = 0; i < PROF; i++)
                buffer[i] <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (registra) begin
                        if (bcd_invalido(distancia)) begin
                            erro <= 1'b1;
                        end else begin
                            amostra <= LARG_BIN'(bcd_para_bin(distancia));
                            erro    <= 1'b0;
                            ocupado <= 1'b1;
                            estado  <= ACUMULA;
                        end
                    end
                end
                ACUMULA: begin
                    // First sample after reset fills the whole window so the
                    // average starts at the sample value instead of ramping up.
                    if (primeira) begin
                        for (int i = 0; i < PROF; i++)
                            buffer[i] <= amostra;
                        soma     <= SOMA_W'(amostra) << LOG2_AMOSTRAS;
                        ptr      <= LOG2_AMOSTRAS'(1);
                        primeira <= 1'b0;
                    end else begin
                        soma        <= soma - SOMA_W'(buffer[ptr]) + SOMA_W'(amostra);
                        buffer[ptr] <= amostra;
                        ptr         <= ptr + LOG2_AMOSTRAS'(1);
                    end
                    estado <= CARREGA;
                end
                CARREGA: begin
                    media_calc <= conv_bin;
                    estado     <= CONVERTE;
                end
                CONVERTE: begin
                    if (conv_pronto) begin
                        media     <= conv_bcd;
                        media_bin <= media_calc;
                        pronto    <= 1'b1;
                        estado    <= PRONTO;
                    end
                end
                PRONTO: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_media_movel_hcsr04.sv
// Scoreboard bench for media_movel_hcsr04: a window model queues expected
// averages when samples are driven; each test pops them when pronto fires.
module tb_media_movel_hcsr04;

    logic        clock;
    logic        reset;
    logic        registra;
    logic [11:0] distancia;
    logic [11:0] media;
    logic [9:0]  media_bin;
    logic        pronto;
    logic        ocupado;
    logic        erro;

    int checks;
    int failures;

    logic [21:0] esperado_q [$];
    int  mbuf [4];
    int  msum;
    int  mptr;
    bit  mprim;

    media_movel_hcsr04 dut (
        .clock     (clock),
        .reset     (reset),
        .registra  (registra),
        .distancia (distancia),
        .media     (media),
        .media_bin (media_bin),
        .pronto    (pronto),
        .ocupado   (ocupado),
        .erro      (erro)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [11:0] para_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        mprim = 1'b1;
        msum  = 0;
        mptr  = 0;
        for (int k = 0; k < 4; k++) mbuf[k] = 0;
        esperado_q.delete();
    endtask

    task automatic model_amostra(input logic [11:0] d);
        int b;
        int avg;
        if (d[11:8] > 4'd9 || d[7:4] > 4'd9 || d[3:0] > 4'd9) return;
        b = int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
        if (mprim) begin
            for (int k = 0; k < 4; k++) mbuf[k] = b;
            msum  = b * 4;
            mptr  = 1;
            mprim = 1'b0;
        end else begin
            msum       = msum - mbuf[mptr] + b;
            mbuf[mptr] = b;
            mptr       = (mptr + 1) % 4;
        end
        avg = msum / 4;
        esperado_q.push_back({para_bcd(avg), 10'(avg)});
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        registra = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one strobe; returns just after the sampling edge E0.
    task automatic send(input logic [11:0] d);
        registra  = 1'b1;
        distancia = d;
        model_amostra(d);
        @(posedge clock); #1;
        registra = 1'b0;
    endtask

    task automatic wait_pronto(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (pronto === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        registra  = 1'b1;
        distancia = 12'h123;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if ({media, media_bin, pronto, ocupado, erro} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%0d p=%b o=%b e=%b exp=0", media, media_bin, pronto, ocupado, erro);
        end
        reset    = 1'b0;
        registra = 1'b0;
        model_reset();
        @(posedge clock); #1;
        checks++;
        if (ocupado !== 1'b0 || pronto !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got o=%b p=%b exp o=0 p=0", ocupado, pronto);
        end
    endtask

    task automatic test_primeira();
        int lat;
        logic [21:0] exp_v;
        send(12'h123);
        checks++;
        if (ocupado !== 1'b1) begin
            failures++;
            $display("FAIL primeira_ocupado got=%b exp=1", ocupado);
        end
        wait_pronto(lat);
        checks++;
        if (lat != 12) begin
            failures++;
            $display("FAIL primeira_latencia got=%0d exp=12", lat);
        end
        exp_v = esperado_q.pop_front();
        checks++;
        if (media !== exp_v[21:10] || media !== 12'h123 || media_bin !== 10'd123 || erro !== 1'b0) begin
            failures++;
            $display("FAIL primeira_media got=%h/%0d e=%b exp=%h/%0d e=0", media, media_bin, erro, exp_v[21:10], exp_v[9:0]);
        end
        @(posedge clock); #1;
        checks++;
        if (pronto !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL primeira_pulso got p=%b o=%b exp p=0 o=0", pronto, ocupado);
        end
    endtask

    task automatic test_janela();
        logic [11:0] amostras [3] = '{12'h127, 12'h131, 12'h139};
        logic [11:0] medias   [3] = '{12'h124, 12'h126, 12'h130};
        int lat;
        logic [21:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            send(amostras[k]);
            wait_pronto(lat);
            exp_v = esperado_q.pop_front();
            checks++;
            if (lat != 12 || media !== exp_v[21:10] || media_bin !== exp_v[9:0] || media !== medias[k]) begin
                failures++;
                $display("FAIL janela_%0d got lat=%0d %h/%0d exp lat=12 %h/%0d", k, lat, media, media_bin, medias[k], exp_v[9:0]);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_invalido();
        int lat;
        int npronto;
        bit ocup;
        logic [21:0] exp_v;
        send(12'h1A5);
        checks++;
        if (erro !== 1'b1 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL invalido_erro got e=%b o=%b exp e=1 o=0", erro, ocupado);
        end
        npronto = 0;
        ocup    = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (pronto === 1'b1) npronto++;
            if (ocupado !== 1'b0) ocup = 1'b1;
        end
        checks++;
        if (npronto != 0 || ocup || media !== 12'h130) begin
            failures++;
            $display("FAIL invalido_sem_pronto got np=%0d busy=%b media=%h exp np=0 busy=0 media=130", npronto, ocup, media);
        end
        send(12'h130);
        checks++;
        if (erro !== 1'b0) begin
            failures++;
            $display("FAIL invalido_limpa got=%b exp=0", erro);
        end
        wait_pronto(lat);
        exp_v = esperado_q.pop_front();
        checks++;
        if (lat != 12 || media !== exp_v[21:10] || media !== 12'h131 || media_bin !== 10'd131) begin
            failures++;
            $display("FAIL invalido_media got lat=%0d %h/%0d exp lat=12 131/131", lat, media, media_bin);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_ignorado();
        int npronto;
        int lat;
        logic [11:0] m_vista;
        logic [9:0]  mb_vista;
        logic [21:0] exp_v;
        send(12'h140);
        npronto = 0;
        lat     = -1;
        m_vista  = '0;
        mb_vista = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3 || i == 7) begin
                registra  = 1'b1;
                distancia = 12'h900;
            end else begin
                registra = 1'b0;
            end
            @(posedge clock); #1;
            if (pronto === 1'b1) begin
                npronto++;
                if (lat < 0) begin
                    lat      = i;
                    m_vista  = media;
                    mb_vista = media_bin;
                end
            end
        end
        registra = 1'b0;
        exp_v = esperado_q.pop_front();
        checks++;
        if (npronto != 1 || lat != 12) begin
            failures++;
            $display("FAIL ignorado_pronto got np=%0d lat=%0d exp np=1 lat=12", npronto, lat);
        end
        checks++;
        if (m_vista !== exp_v[21:10] || mb_vista !== exp_v[9:0] || media !== exp_v[21:10] || erro !== 1'b0) begin
            failures++;
            $display("FAIL ignorado_media got %h/%0d e=%b exp %h/%0d e=0", m_vista, mb_vista, erro, exp_v[21:10], exp_v[9:0]);
        end
    endtask

    task automatic test_saturacao();
        int lat;
        logic [21:0] exp_v;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(12'h999);
            wait_pronto(lat);
            exp_v = esperado_q.pop_front();
            checks++;
            if (lat != 12 || media !== 12'h999 || media_bin !== 10'd999 || media !== exp_v[21:10]) begin
                failures++;
                $display("FAIL saturacao_%0d got lat=%0d %h/%0d exp lat=12 999/999", k, lat, media, media_bin);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_aborto();
        int npronto;
        int lat;
        logic [21:0] exp_v;
        send(12'h500);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({media, media_bin, pronto, ocupado, erro} !== 25'd0) begin
            failures++;
            $display("FAIL aborto_reset got=%h/%0d p=%b o=%b e=%b exp=0", media, media_bin, pronto, ocupado, erro);
        end
        reset = 1'b0;
        model_reset();
        npronto = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (pronto === 1'b1) npronto++;
        end
        checks++;
        if (npronto != 0) begin
            failures++;
            $display("FAIL aborto_sem_pronto got=%0d exp=0", npronto);
        end
        send(12'h050);
        wait_pronto(lat);
        exp_v = esperado_q.pop_front();
        checks++;
        if (lat != 12 || media !== 12'h050 || media_bin !== 10'd50 || media !== exp_v[21:10]) begin
            failures++;
            $display("FAIL aborto_prefill got lat=%0d %h/%0d exp lat=12 050/50", lat, media, media_bin);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        registra  = 1'b0;
        distancia = '0;
        model_reset();
        test_reset();
        test_primeira();
        test_janela();
        test_invalido();
        test_ignorado();
        test_saturacao();
        test_aborto();
        checks++;
        if (esperado_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_vazio got=%0d exp=0", esperado_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
